// File: rtl/beta_pkg.sv
// Shared types for the beta instruction/data memory port arbiter.
// Optional round-robin arbitration is enabled with `define BETA_ARB_ROUND_ROBIN_EN.
package beta_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_HOLD     = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_IF = 1'b0,
        ARB_OWN_LS = 1'b1
    } arb_owner_t;

    function automatic arb_owner_t arb_other(input arb_owner_t o);
        return (o == ARB_OWN_IF) ? ARB_OWN_LS : ARB_OWN_IF;
    endfunction

endpackage

// File: rtl/beta_arb_select.sv
// Winner selection between fetch and LSU requests.
// With BETA_ARB_ROUND_ROBIN_EN defined, ties go to whoever did not win last.
module beta_arb_select
    import beta_pkg::*;
(
`ifdef BETA_ARB_ROUND_ROBIN_EN
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_update,
    input  arb_owner_t i_granted,
`endif
    input  logic       i_if_req,
    input  logic       i_ls_req,
    output arb_owner_t o_winner
);

`ifdef BETA_ARB_ROUND_ROBIN_EN
    arb_owner_t r_last;

    // Resetting to IF makes the LSU the first winner of a tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= ARB_OWN_IF;
        end else if (i_update) begin
            r_last <= i_granted;
        end
    end

    always_comb begin
        o_winner = ARB_OWN_IF;
        if (i_if_req && i_ls_req) begin
            o_winner = arb_other(r_last);
        end else if (i_ls_req) begin
            o_winner = ARB_OWN_LS;
        end
    end
`else
    always_comb begin
        o_winner = i_ls_req ? ARB_OWN_LS : ARB_OWN_IF;
    end

    logic w_unused;
    assign w_unused = i_if_req;
`endif

endmodule

// File: rtl/beta_imem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Define BETA_ARB_ROUND_ROBIN_EN for round-robin instead of fixed LSU-over-IF priority.
module beta_imem_arbiter
    import beta_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   arb_if_req_i,
    input  logic [AddrWidth-1:0]   arb_if_addr_i,
    output logic                   arb_if_ready_o,
    output logic                   arb_if_valid_o,
    output logic [DataWidth-1:0]   arb_if_rdata_o,
    input  logic                   arb_ls_req_i,
    input  logic                   arb_ls_we_i,
    input  logic [DataWidth/8-1:0] arb_ls_be_i,
    input  logic [AddrWidth-1:0]   arb_ls_addr_i,
    input  logic [DataWidth-1:0]   arb_ls_wdata_i,
    output logic                   arb_ls_ready_o,
    output logic                   arb_ls_valid_o,
    output logic [DataWidth-1:0]   arb_ls_rdata_o,
    output logic                   arb_mem_req_o,
    output logic                   arb_mem_we_o,
    output logic [DataWidth/8-1:0] arb_mem_be_o,
    output logic [AddrWidth-1:0]   arb_mem_addr_o,
    output logic [DataWidth-1:0]   arb_mem_wdata_o,
    input  logic                   arb_mem_ready_i,
    input  logic                   arb_mem_valid_i,
    input  logic [DataWidth-1:0]   arb_mem_rdata_i,
    output logic                   arb_owner_o,
    output logic                   arb_busy_o,
    output logic                   arb_err_o
);

    localparam int BeWidth = DataWidth / 8;

    arb_state_t r_state, w_state_next;
    arb_owner_t r_owner, w_owner_next;
    logic       r_err,   w_err_next;

    arb_owner_t w_winner;
    arb_owner_t w_sel;
    arb_owner_t w_mux_sel;
    logic       w_sel_req;
    logic       w_mem_req;
    logic       w_grant;
    logic       w_rsp;
    logic       w_enter_wait;
    logic       w_run;

    beta_arb_select u_sel (
`ifdef BETA_ARB_ROUND_ROBIN_EN
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_update  (w_enter_wait),
        .i_granted (w_owner_next),
`endif
        .i_if_req  (arb_if_req_i),
        .i_ls_req  (arb_ls_req_i),
        .o_winner  (w_winner)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_owner <= ARB_OWN_IF;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_err   <= w_err_next;
        end
    end

    // In IDLE the selected requester is the combinational winner; otherwise the locked owner.
    assign w_sel     = (r_state == ARB_IDLE) ? w_winner : r_owner;
    assign w_sel_req = (w_sel == ARB_OWN_LS) ? arb_ls_req_i : arb_if_req_i;

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_err_next   = r_err;
        w_mem_req    = 1'b0;
        w_grant      = 1'b0;
        w_rsp        = 1'b0;
        w_enter_wait = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_mem_req = w_sel_req;
                w_grant   = w_sel_req & arb_mem_ready_i;
                if (arb_mem_valid_i) begin
                    w_err_next = 1'b1;
                end
                if (w_sel_req) begin
                    w_owner_next = w_winner;
                    if (arb_mem_ready_i) begin
                        w_state_next = ARB_WAIT_RSP;
                        w_enter_wait = 1'b1;
                    end else begin
                        w_state_next = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                w_mem_req = w_sel_req;
                w_grant   = w_sel_req & arb_mem_ready_i;
                if (arb_mem_valid_i) begin
                    w_err_next = 1'b1;
                end
                if (!w_sel_req) begin
                    w_state_next = ARB_IDLE;
                end else if (arb_mem_ready_i) begin
                    w_state_next = ARB_WAIT_RSP;
                    w_enter_wait = 1'b1;
                end
            end
            ARB_WAIT_RSP: begin
                if (arb_mem_valid_i) begin
                    w_rsp        = 1'b1;
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // While rst_i is high every output is held at 0, except the payload mux which follows IF.
    assign w_run     = ~rst_i;
    assign w_mux_sel = rst_i ? ARB_OWN_IF : w_sel;

    assign arb_mem_req_o   = w_run & w_mem_req;
    assign arb_mem_addr_o  = (w_mux_sel == ARB_OWN_LS) ? arb_ls_addr_i : arb_if_addr_i;
    assign arb_mem_wdata_o = (w_mux_sel == ARB_OWN_LS) ? arb_ls_wdata_i : '0;
    assign arb_mem_we_o    = (w_mux_sel == ARB_OWN_LS) & arb_ls_we_i;
    assign arb_mem_be_o    = {BeWidth{w_mux_sel == ARB_OWN_LS}} & arb_ls_be_i;

    assign arb_if_ready_o  = w_run & w_grant & (w_sel == ARB_OWN_IF);
    assign arb_ls_ready_o  = w_run & w_grant & (w_sel == ARB_OWN_LS);

    assign arb_if_valid_o  = w_run & w_rsp & (r_owner == ARB_OWN_IF);
    assign arb_ls_valid_o  = w_run & w_rsp & (r_owner == ARB_OWN_LS);
    assign arb_if_rdata_o  = arb_if_valid_o ? arb_mem_rdata_i : '0;
    assign arb_ls_rdata_o  = arb_ls_valid_o ? arb_mem_rdata_i : '0;

    assign arb_owner_o     = w_run & (r_owner == ARB_OWN_LS);
    assign arb_busy_o      = w_run & (r_state != ARB_IDLE);
    assign arb_err_o       = w_run & r_err;

endmodule

// File: tb/tb_beta_imem_arbiter.sv
// Directed bench for beta_imem_arbiter: expected responses are queued by the stimulus
// and consumed by a monitor whenever either valid output rises.
module tb_beta_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready, if_valid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ready, ls_valid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_rdata;
    logic        owner, busy, err;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rsp = 0;

    always #5 clk = ~clk;

    beta_imem_arbiter #(.DataWidth(32), .AddrWidth(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .arb_if_req_i    (if_req),
        .arb_if_addr_i   (if_addr),
        .arb_if_ready_o  (if_ready),
        .arb_if_valid_o  (if_valid),
        .arb_if_rdata_o  (if_rdata),
        .arb_ls_req_i    (ls_req),
        .arb_ls_we_i     (ls_we),
        .arb_ls_be_i     (ls_be),
        .arb_ls_addr_i   (ls_addr),
        .arb_ls_wdata_i  (ls_wdata),
        .arb_ls_ready_o  (ls_ready),
        .arb_ls_valid_o  (ls_valid),
        .arb_ls_rdata_o  (ls_rdata),
        .arb_mem_req_o   (mem_req),
        .arb_mem_we_o    (mem_we),
        .arb_mem_be_o    (mem_be),
        .arb_mem_addr_o  (mem_addr),
        .arb_mem_wdata_o (mem_wdata),
        .arb_mem_ready_i (mem_ready),
        .arb_mem_valid_i (mem_valid),
        .arb_mem_rdata_i (mem_rdata),
        .arb_owner_o     (owner),
        .arb_busy_o      (busy),
        .arb_err_o       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
        mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        rsp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: samples mid-phase after the stimulus has settled.
    always @(negedge clk) begin
        #2;
        if (if_valid || ls_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got if_valid=%b ls_valid=%b, expected none", if_valid, ls_valid);
            end else begin
                mon_e = exp_q.pop_front();
                n_rsp++;
                $display("rsp %0d: port=%s data=%h", n_rsp, ls_valid ? "LS" : "IF", ls_valid ? ls_rdata : if_rdata);
                check("rsp_onehot", {31'd0, if_valid & ls_valid}, 32'd0);
                check("rsp_port", {31'd0, ls_valid}, {31'd0, mon_e.port});
                check("rsp_data", ls_valid ? ls_rdata : if_rdata, mon_e.data);
                check("rsp_other_rdata", ls_valid ? if_rdata : ls_rdata, 32'd0);
            end
        end
    end

    initial begin
        logic exp_ls;
        clr();
        rst_i = 1'b1;
        next();

        // Reset: outputs quiet even with live requests, payload mux follows IF.
        if_req = 1'b1; if_addr = 32'h0000_0C00; mem_ready = 1'b1; mem_valid = 1'b1;
        ls_wdata = 32'hFFFF_FFFF;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_err", err, 0);
        check("rst_mem_addr", mem_addr, 32'h0000_0C00);
        check("rst_mem_wdata", mem_wdata, 0);
        next();
        clr(); rst_i = 1'b0;
        next();

        // IF-only read.
        if_req = 1'b1; if_addr = 32'h0000_0010; mem_ready = 1'b1;
        #1;
        check("if_ready", if_ready, 1);
        check("if_ls_ready", ls_ready, 0);
        check("if_mem_req", mem_req, 1);
        check("if_mem_addr", mem_addr, 32'h0000_0010);
        check("if_mem_we", mem_we, 0);
        next();
        clr(); mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; push(1'b0, 32'hDEAD_BEEF);
        #1;
        check("if_wait_busy", busy, 1);
        check("if_wait_owner", owner, 0);
        check("if_wait_mem_req", mem_req, 0);
        next();
        clr();
        #1 check("if_idle_busy", busy, 0);

        // Simultaneous requests.
        for (int i = 0; i < 4; i++) begin
            clr();
            if_req = 1'b1; if_addr = 32'h0000_0040 + 32'(i * 4);
            ls_addr = 32'h0000_0020 + 32'(i * 4);
`ifdef BETA_ARB_ROUND_ROBIN_EN
            ls_req = 1'b1;
            exp_ls = (i % 2 == 0);
`else
            ls_req = (i < 2);
            exp_ls = (i < 2);
`endif
            mem_ready = 1'b1;
            #1;
            check("sim_ls_ready", ls_ready, exp_ls);
            check("sim_if_ready", if_ready, !exp_ls);
            check("sim_mem_addr", mem_addr, exp_ls ? ls_addr : if_addr);
            next();
            mem_valid = 1'b1; mem_rdata = 32'h0000_1000 + i;
            push(exp_ls, 32'h0000_1000 + i);
            #1;
            check("sim_owner", owner, exp_ls);
            check("sim_bubble_req", mem_req, 0);
            check("sim_wait_ready", if_ready | ls_ready, 0);
            next();
        end

        // Owner drops its request in HOLD.
        clr(); if_req = 1'b1; if_addr = 32'h0000_0060;
        #1;
        check("drop_mem_req", mem_req, 1);
        check("drop_if_ready", if_ready, 0);
        next();
        clr();
        #1;
        check("drop_hold_busy", busy, 1);
        check("drop_hold_req", mem_req, 0);
        next();
        #1 check("drop_idle_busy", busy, 0);

        // LSU write stalled in HOLD while IF waits.
        clr();
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h0000_0080; ls_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h0000_0044;
        #1;
        check("stall_ls_ready0", ls_ready, 0);
        check("stall_mem_we", mem_we, 1);
        next();
        for (int k = 0; k < 2; k++) begin
            if_addr = 32'h0000_0048 + 32'(k * 4);
            #1;
            check("stall_busy", busy, 1);
            check("stall_mem_addr", mem_addr, 32'h0000_0080);
            check("stall_mem_wdata", mem_wdata, 32'h1234_5678);
            check("stall_mem_be", {28'd0, mem_be}, 32'hF);
            check("stall_if_ready", if_ready, 0);
            check("stall_ls_ready", ls_ready, 0);
            next();
        end
        mem_ready = 1'b1;
        #1;
        check("stall_accept", ls_ready, 1);
        check("stall_accept_if", if_ready, 0);
        check("stall_accept_addr", mem_addr, 32'h0000_0080);
        next();
        ls_req = 1'b0; mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = '0;
        push(1'b1, 32'h0);
        #1;
        check("stall_bubble", mem_req, 0);
        check("stall_owner", owner, 1);
        next();
        mem_valid = 1'b0; mem_ready = 1'b1; if_addr = 32'h0000_0044;
        #1;
        check("after_if_ready", if_ready, 1);
        check("after_mem_addr", mem_addr, 32'h0000_0044);
        check("after_mem_we", mem_we, 0);
        check("after_mem_be", {28'd0, mem_be}, 0);
        check("after_mem_wdata", mem_wdata, 0);
        next();
        clr(); mem_valid = 1'b1; mem_rdata = 32'h0A0A_0A0A; push(1'b0, 32'h0A0A_0A0A);
        next();

        // Reset during WAIT_RSP, then a late response.
        clr(); if_req = 1'b1; if_addr = 32'h0000_0100; mem_ready = 1'b1;
        next();
        clr();
        #1 check("mid_busy", busy, 1);
        rst_i = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", mem_req, 0);
        next();
        rst_i = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        check("late_if_valid", if_valid, 0);
        check("late_ls_valid", ls_valid, 0);
        next();
        clr();
        #1;
        check("late_err", err, 1);
        check("late_busy", busy, 0);
        if_req = 1'b1; if_addr = 32'h0000_0200; mem_ready = 1'b1;
        #1 check("late_if_ready", if_ready, 1);
        next();
        clr(); mem_valid = 1'b1; mem_rdata = 32'h5555_AAAA; push(1'b0, 32'h5555_AAAA);
        #1 check("late_err_held", err, 1);
        next();

        // Spurious response in IDLE.
        clr(); rst_i = 1'b1;
        next();
        rst_i = 1'b0;
        #1 check("sp_err_clear", err, 0);
        mem_valid = 1'b1; mem_rdata = 32'h0000_0077;
        #1;
        check("sp_if_valid", if_valid, 0);
        check("sp_ls_valid", ls_valid, 0);
        next();
        clr();
        #1 check("sp_err_set", err, 1);
        next();
        next();
        #1 check("sp_err_sticky", err, 1);
        rst_i = 1'b1;
        next();
        rst_i = 1'b0;
        #1 check("sp_err_reset", err, 0);
        next();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/beta_imem_arbiter.md
Name: beta_imem_arbiter

Overview:
- Shares a single memory port between the instruction fetch stage and the load/store unit.
- Sits between the fetch unit / LSU request ports and the memory-side bus. It uses the same req/ready/valid/rdata handshake on every side.
- Arbitrates between the two requesters and locks the winner through the transaction.
- Routes the response back to the owner, with at most one transaction in flight.

Parameters:
- DataWidth, 32, width of rdata/wdata.
- AddrWidth, 32, width of address lines.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- arb_if_req_i  in  1  fetch request
- arb_if_addr_i  in  AddrWidth  fetch address (PC)
- arb_if_ready_o  out  1  fetch request accepted
- arb_if_valid_o  out  1  fetch data valid
- arb_if_rdata_o  out  DataWidth  fetch data
- arb_ls_req_i  in  1  LSU request
- arb_ls_we_i  in  1  LSU write enable
- arb_ls_be_i  in  DataWidth/8  LSU byte enables
- arb_ls_addr_i  in  AddrWidth  LSU address
- arb_ls_wdata_i  in  DataWidth  LSU write data
- arb_ls_ready_o  out  1  LSU request accepted
- arb_ls_valid_o  out  1  LSU response valid (reads and writes)
- arb_ls_rdata_o  out  DataWidth  LSU read data
- arb_mem_req_o  out  1  memory request
- arb_mem_we_o  out  1  memory write enable
- arb_mem_be_o  out  DataWidth/8  memory byte enables
- arb_mem_addr_o  out  AddrWidth  memory address
- arb_mem_wdata_o  out  DataWidth  memory write data
- arb_mem_ready_i  in  1  memory accepted request
- arb_mem_valid_i  in  1  memory response valid
- arb_mem_rdata_i  in  DataWidth  memory read data
- arb_owner_o  out  1  current/last owner (0 = IF, 1 = LSU)
- arb_busy_o  out  1  transaction pending (state != IDLE)
- arb_err_o  out  1  sticky: arb_mem_valid_i seen in IDLE or HOLD

Behaviour:
- FSM states: IDLE, HOLD, WAIT_RSP. Registers: state, owner, err.
- Reset values: state = IDLE, owner = 0, err = 0.
  - All outputs are 0 in reset, with one exception: the mem-side address/data muxes follow the IF port (owner = 0).
- IDLE:
  - Winner is selected combinationally from the req inputs.
  - arb_mem_req_o and the payload are driven in the same cycle (zero-latency passthrough).
  - The winner's ready output = arb_mem_ready_i. The loser's ready is 0.
  - If arb_mem_ready_i is high: owner <= winner, go to WAIT_RSP.
  - Else, if any req is high: owner <= winner, go to HOLD.
- HOLD:
  - Memory port is driven from the owner only; the other requester is ignored.
  - The owner must keep req and payload stable until ready.
  - On arb_mem_ready_i, go to WAIT_RSP.
  - If the owner drops req (protocol violation), return to IDLE.
- WAIT_RSP:
  - arb_mem_req_o = 0 and both ready outputs = 0.
  - On arb_mem_valid_i: the owner's valid = 1 and rdata = arb_mem_rdata_i in the same cycle (combinational routing); go to IDLE.
  - No new request is issued in the valid cycle, so there is a 1-cycle bubble between transactions.
  - The non-owner's valid is always 0. Its rdata is 0.
- Default arbitration: fixed priority, LSU over IF.
- arb_mem_we_o and arb_mem_be_o are forced to 0 when the owner is IF.
- arb_mem_valid_i in IDLE/HOLD: ignored (not forwarded) and sets arb_err_o. err is cleared only by rst_i.
- Reset mid-transaction: the FSM returns to IDLE and the in-flight response is dropped.
  - A late arb_mem_valid_i after reset sets arb_err_o and is not forwarded.
- Throughput: one transaction per 2 cycles minimum (accept in IDLE, valid in WAIT_RSP next cycle, then IDLE).

Optional Feature:
- Macro: BETA_ARB_ROUND_ROBIN_EN
- Defined:
  - A registered last-winner bit is added (reset to IF).
  - On simultaneous requests in IDLE, the requester that did not win last gets the grant.
  - The last-winner bit updates on entry to WAIT_RSP.
- Undefined: fixed LSU-over-IF priority and no extra register.

Decomposition:
- Shared package beta_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_HOLD, ARB_WAIT_RSP}.
  - typedef enum logic arb_owner_t {ARB_OWN_IF = 1'b0, ARB_OWN_LS = 1'b1}.
- One natural sub-module: beta_arb_select.
  - Priority/round-robin winner logic, including the last-winner register when the macro is enabled.
- FSM and muxing stay in the top module.

Test Plan:
- IF-only read:
  - Stimulus: if_req = 1, addr = 0x0000_0010, mem_ready = 1 same cycle, mem_valid next cycle with rdata = 0xDEAD_BEEF.
  - Required: if_ready = 1 in cycle 0; if_valid = 1 with rdata 0xDEAD_BEEF in cycle 1; ls_valid = 0; mem_we = 0.
- Simultaneous requests, macro off:
  - Stimulus: IF and LSU both request for 2 transactions.
  - Required: LSU granted both times (owner = 1); IF granted only after ls_req drops.
- Simultaneous requests, macro on:
  - Stimulus: IF and LSU both request continuously.
  - Required: grants alternate LSU, IF, LSU, IF (first winner LSU since last-winner resets to IF).
- Stall in HOLD:
  - Stimulus: LSU write (we = 1, be = 0xF, wdata = 0x1234_5678); mem_ready low 3 cycles; IF requests meanwhile.
  - Required: busy = 1; mem_addr/wdata stay LSU's for 3 cycles; if_ready = 0; accept on cycle 4; ls_valid on response.
- Reset mid-transaction:
  - Stimulus: rst_i in WAIT_RSP, then mem_valid one cycle after reset.
  - Required: no valid forwarded to either port; err = 1; state IDLE; next IF request served normally.
- Spurious response:
  - Stimulus: mem_valid = 1 in IDLE.
  - Required: both valid outputs 0; arb_err_o = 1 and stays 1 until reset.
